// File: rtl/pc_pkg.sv
// Shared flow-select encodings and address step for the program-counter unit.
package pc_pkg;

   localparam logic [2:0] MODE_SEQ    = 3'd0;
   localparam logic [2:0] MODE_BRANCH = 3'd1;
   localparam logic [2:0] MODE_JUMP   = 3'd2;
   localparam logic [2:0] MODE_JR     = 3'd3;
   localparam logic [2:0] MODE_CALL   = 3'd4;
   localparam logic [2:0] MODE_RET    = 3'd5;

   localparam int PC_STEP = 4;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control and status bundle between the CPU front end and the PC sequencer.
interface pc_sequencer_if #(
   parameter int ADDR_W = 32,
   parameter int OFF_W  = 16,
   parameter int TGT_W  = 26
);
   logic              stall;
   logic [2:0]        mode;
   logic              taken;
   logic [OFF_W-1:0]  offset;
   logic [TGT_W-1:0]  target;
   logic [ADDR_W-1:0] reg_addr;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] pc_plus4;
   logic              ras_empty;
   logic              ras_full;
   logic              ras_ovf;
   logic              ras_unf;

   modport master (
      output stall, mode, taken, offset, target, reg_addr,
      input  pc, pc_plus4, ras_empty, ras_full, ras_ovf, ras_unf
   );

   modport slave (
      input  stall, mode, taken, offset, target, reg_addr,
      output pc, pc_plus4, ras_empty, ras_full, ras_ovf, ras_unf
   );
endinterface

// File: rtl/pc_sequencer_return_addr_stack.sv
// Circular return-address stack: a push when full overwrites the oldest entry,
// a pop when empty only flags underflow.
module return_addr_stack #(
   parameter int RAS_DEPTH = 4,
   parameter int ADDR_W    = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic              pop,
   input  logic [ADDR_W-1:0] din,
   output logic [ADDR_W-1:0] top,
   output logic              empty,
   output logic              full,
   output logic              ovf,
   output logic              unf
);
   localparam int PTR_W = $clog2(RAS_DEPTH);

   logic [PTR_W-1:0]  ptr_reg;
   logic [PTR_W:0]    count_reg;
   logic              ovf_reg;
   logic              unf_reg;
   logic [ADDR_W-1:0] mem_reg [RAS_DEPTH];
   logic [PTR_W-1:0]  top_idx;

   // ptr_reg names the next slot to write, which is also the oldest entry once full
   assign top_idx = ptr_reg - PTR_W'(1);
   assign top     = mem_reg[top_idx];
   assign empty   = (count_reg == '0);
   assign full    = (count_reg == (PTR_W+1)'(RAS_DEPTH));
   assign ovf     = ovf_reg;
   assign unf     = unf_reg;

   generate
      for (genvar gi = 0; gi < RAS_DEPTH; gi++) begin : g_entry
         always_ff @(posedge clk) begin
            if (push && ptr_reg == PTR_W'(gi)) begin
               mem_reg[gi] <= din;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_reg   <= '0;
         count_reg <= '0;
         ovf_reg   <= 1'b0;
         unf_reg   <= 1'b0;
      end else begin
         ovf_reg <= 1'b0;
         unf_reg <= 1'b0;
         if (push) begin
            ptr_reg <= ptr_reg + PTR_W'(1);
            if (full) begin
               ovf_reg <= 1'b1;
            end else begin
               count_reg <= count_reg + (PTR_W+1)'(1);
            end
         end else if (pop) begin
            if (empty) begin
               unf_reg <= 1'b1;
            end else begin
               ptr_reg   <= top_idx;
               count_reg <= count_reg - (PTR_W+1)'(1);
            end
         end
      end
   end
endmodule

// File: rtl/pc_sequencer.sv
// Registered program counter with next-address select for sequential, branch,
// jump, jump-register, call and return flows.
module pc_sequencer
   import pc_pkg::*;
#(
   parameter int              ADDR_W    = 32,
   parameter int              OFF_W     = 16,
   parameter int              TGT_W     = 26,
   parameter int              RAS_DEPTH = 4,
   parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
   input logic           clk,
   input logic           rst_n,
   pc_sequencer_if.slave bus
);
   logic [ADDR_W-1:0] pc_reg;
   logic [ADDR_W-1:0] pc_next;
   logic [ADDR_W-1:0] pc_plus4;
   logic [ADDR_W-1:0] branch_off;
   logic [ADDR_W-1:0] jump_addr;
   logic [ADDR_W-1:0] ras_top;
   logic              ras_empty;
   logic              ras_full;
   logic              ras_ovf;
   logic              ras_unf;
   logic              push;
   logic              pop;

   assign pc_plus4   = pc_reg + ADDR_W'(PC_STEP);
   // Word offset sign-extended then scaled to bytes
   assign branch_off = {{(ADDR_W-OFF_W){bus.offset[OFF_W-1]}}, bus.offset} << 2;
   assign jump_addr  = {pc_plus4[ADDR_W-1:TGT_W+2], bus.target, 2'b00};

   assign push = !bus.stall && (bus.mode == MODE_CALL);
   assign pop  = !bus.stall && (bus.mode == MODE_RET);

   always_comb begin
      pc_next = pc_plus4;
      unique case (bus.mode)
         MODE_BRANCH: if (bus.taken) pc_next = pc_plus4 + branch_off;
         MODE_JUMP:   pc_next = jump_addr;
         MODE_JR:     pc_next = {bus.reg_addr[ADDR_W-1:2], 2'b00};
         MODE_CALL:   pc_next = jump_addr;
         MODE_RET:    if (!ras_empty) pc_next = ras_top;
         default:     pc_next = pc_plus4;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_reg <= RESET_VEC;
      end else if (!bus.stall) begin
         pc_reg <= pc_next;
      end
   end

   return_addr_stack #(
      .RAS_DEPTH (RAS_DEPTH),
      .ADDR_W    (ADDR_W)
   ) u_ras (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .din   (pc_plus4),
      .top   (ras_top),
      .empty (ras_empty),
      .full  (ras_full),
      .ovf   (ras_ovf),
      .unf   (ras_unf)
   );

   assign bus.pc        = pc_reg;
   assign bus.pc_plus4  = pc_plus4;
   assign bus.ras_empty = ras_empty;
   assign bus.ras_full  = ras_full;
   assign bus.ras_ovf   = ras_ovf;
   assign bus.ras_unf   = ras_unf;
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Registered program-counter unit for the single-cycle CPU; the next generation of the combinational next-address logic. It holds the PC, computes the next address for sequential, branch, jump, jump-register, call and return flows, supports stall, and keeps a small return-address stack (RAS). All widths, the reset vector and the RAS depth are parameters.

## Interface
- ADDR_W, 32, PC/address width
- OFF_W, 16, branch offset width (word offset, signed)
- TGT_W, 26, absolute jump target width (word index)
- RAS_DEPTH, 4, return-address stack entries (power of two, ≥2)
- RESET_VEC, 0, PC value after reset (word aligned)

- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- stall  in  1  1 = hold PC and RAS this cycle
- mode  in  3  flow select (see Operation)
- taken  in  1  branch condition, used only in BRANCH mode
- offset  in  OFF_W  signed word offset for BRANCH
- target  in  TGT_W  word target for JUMP/CALL
- reg_addr  in  ADDR_W  register-sourced address for JR
- pc  out  ADDR_W  current PC (registered)
- pc_plus4  out  ADDR_W  pc + 4 (combinational)
- ras_empty  out  1  RAS holds no entries
- ras_full  out  1  RAS holds RAS_DEPTH entries
- ras_ovf  out  1  one-cycle pulse: CALL pushed while full
- ras_unf  out  1  one-cycle pulse: RET executed while empty

## Operation
- Modes: 0 SEQ, 1 BRANCH, 2 JUMP, 3 JR, 4 CALL, 5 RET, 6–7 treated as SEQ.
- SEQ: next = pc + 4.
- BRANCH: taken → pc + 4 + (sext(offset) << 2); not taken → pc + 4.
- JUMP: next = {pc_plus4[ADDR_W-1 : TGT_W+2], target, 2'b00}.
- JR: next = {reg_addr[ADDR_W-1:2], 2'b00} (low bits forced to zero).
- CALL: next as JUMP; push pc + 4 onto RAS.
- RET: RAS non-empty → next = top, pop; empty → next = pc + 4, ras_unf pulses, count stays 0.
- RAS is circular: push when full overwrites the oldest entry, count stays RAS_DEPTH, ras_ovf pulses.
- All address arithmetic modulo 2^ADDR_W; wrap-around is silent, no flag.

## Timing
- Reset (rst_n = 0 at edge): pc = RESET_VEC, RAS count = 0, ras_empty = 1, ras_full = 0, ras_ovf = ras_unf = 0. Reset dominates stall and mode.
- Next-PC is combinational from pc and inputs; pc updates at the next rising edge: latency 1 cycle.
- stall = 1: pc, RAS pointer, count and contents unchanged; ras_ovf/ras_unf stay 0 that cycle.
- ras_ovf/ras_unf are registered, high for exactly the cycle after the offending edge.
- ras_empty/ras_full derive from registered count; valid the cycle after the push/pop.
- Reset mid-sequence discards all RAS contents; no return after reset reaches pre-reset addresses.
- Inputs other than those selected by mode are don't-care.

## Structure
- Shared package pc_pkg: mode constants (MODE_SEQ..MODE_RET), PC_STEP = 4.
- One sub-module: return_addr_stack (RAS_DEPTH, ADDR_W; push, pop, data in, top, empty, full, ovf, unf); pc_sequencer holds the PC register and next-address mux.

## Test plan
- Reset with RESET_VEC = 0x100, then 3 cycles SEQ -> pc = 0x100, 0x104, 0x108, 0x10C.
- pc = 0x20, BRANCH taken offset = 0xFFFF -> pc = 0x20; offset = 1 -> 0x28; taken = 0 -> 0x24.
- pc = 0x30, CALL target = 0x40 -> pc = 0x100, RAS top 0x34; RET -> pc = 0x34, ras_empty = 1.
- Five CALLs with RAS_DEPTH = 4 -> ras_ovf pulses once on the fifth; four RETs return the last four pushed addresses in LIFO order; a fifth RET -> pc + 4, ras_unf pulse.
- pc = 0xFFFFFFFC, SEQ -> pc = 0x0; JR reg_addr = 0x1237 -> pc = 0x1234.
- stall = 1 for 3 cycles during CALL -> pc and RAS count unchanged; rst_n = 0 mid-stall -> pc = RESET_VEC, ras_empty = 1.
